// File: rtl/nvram_upload_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nvram_upload_ctrl                                                          |
// | Serves HPS upload byte reads by fetching 16-bit words from SDRAM.          |
// | Optional one-word read cache: define NVRAM_UPLOAD_PREFETCH_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nvram_upload_ctrl #(
  parameter logic [7:0]  INDEX     = 8'd4,
  parameter logic [24:0] BASE_ADDR = 25'h0A1000,
  parameter logic [15:0] SIZE      = 16'd1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_a,
  input  logic [15:0] mem_q,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic        r_hi_sel;
  logic        w_active;
  logic        w_in_range;
  logic        w_ack_eq;
  logic [24:0] w_byte_addr;
  logic [22:0] w_word_addr;
  logic [7:0]  w_fetched_byte;
  logic        w_cache_hit;
  logic [7:0]  w_cache_byte;
  logic        w_unused;

  assign w_active       = ioctl_upload & (ioctl_index == INDEX);
  assign w_in_range     = ioctl_addr < {9'd0, SIZE};
  assign w_ack_eq       = (mem_ack == mem_req);
  assign w_byte_addr    = BASE_ADDR + ioctl_addr;
  assign w_word_addr    = w_byte_addr[23:1];
  assign w_fetched_byte = r_hi_sel ? mem_q[15:8] : mem_q[7:0];
  assign w_unused       = ^{w_byte_addr[24], w_byte_addr[0]};
  assign busy           = (r_state != S_IDLE);

`ifdef NVRAM_UPLOAD_PREFETCH_EN
  logic        r_upload_d;
  logic        r_cache_vld;
  logic [22:0] r_cache_addr;
  logic [15:0] r_cache_data;
  logic        w_upload_rise;

  assign w_upload_rise = ioctl_upload & ~r_upload_d;
  // A read coinciding with a new upload must not trust the old entry.
  assign w_cache_hit   = r_cache_vld & ~w_upload_rise & (r_cache_addr == w_word_addr);
  assign w_cache_byte  = ioctl_addr[0] ? r_cache_data[15:8] : r_cache_data[7:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_upload_d   <= 1'b0;
      r_cache_vld  <= 1'b0;
      r_cache_addr <= 23'd0;
      r_cache_data <= 16'd0;
    end else begin
      r_upload_d <= ioctl_upload;
      if (w_upload_rise) begin
        r_cache_vld <= 1'b0;
      end else if (r_state == S_FETCH) begin
        if (!w_active) begin
          r_cache_vld <= 1'b0;
        end else if (w_ack_eq) begin
          r_cache_vld  <= 1'b1;
          r_cache_addr <= mem_a;
          r_cache_data <= mem_q;
        end
      end
    end
  end
`else
  assign w_cache_hit  = 1'b0;
  assign w_cache_byte = 8'hFF;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hi_sel   <= 1'b0;
      ioctl_din  <= 8'hFF;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_a      <= 23'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_active && ioctl_rd) begin
            if (!w_in_range) begin
              ioctl_din <= 8'hFF;
            end else if (w_cache_hit) begin
              ioctl_din <= w_cache_byte;
            end else begin
              mem_a      <= w_word_addr;
              r_hi_sel   <= ioctl_addr[0];
              mem_req    <= ~mem_req;
              ioctl_wait <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Abort wins over a same-cycle ack; DRAIN then exits on the next cycle.
          if (!w_active) begin
            ioctl_wait <= 1'b0;
            r_state    <= S_DRAIN;
          end else if (w_ack_eq) begin
            ioctl_din  <= w_fetched_byte;
            ioctl_wait <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_ack_eq) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nvram_upload_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nvram_upload_ctrl                                                       |
// | Directed and randomized bench with an SDRAM model and byte-level reference.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nvram_upload_ctrl;

  localparam logic [24:0] C_BASE = 25'h0A1000;
  localparam int          C_SIZE = 1024;
`ifdef NVRAM_UPLOAD_PREFETCH_EN
  localparam bit C_PF = 1'b1;
`else
  localparam bit C_PF = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack;
  logic [22:0] mem_a;
  logic [15:0] mem_q;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int req_edges = 0;
  int mem_lat  = 1;

  // Reference state: SDRAM contents, last byte returned, cached word.
  logic [15:0] sdram [logic [22:0]];
  logic [7:0]  exp_din = 8'hFF;
  bit          c_vld = 1'b0;
  logic [22:0] c_word = 23'd0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_ctrl dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_a        (mem_a),
    .mem_q        (mem_q),
    .busy         (busy)
  );

  function automatic logic [22:0] word_of(input logic [24:0] a);
    logic [24:0] b;
    b = C_BASE + a;
    return b[23:1];
  endfunction

  function automatic logic [15:0] get_word(input logic [22:0] w);
    if (!sdram.exists(w)) sdram[w] = 16'($urandom);
    return sdram[w];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    logic [15:0] w;
    w = get_word(word_of(a));
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // SDRAM port model: the DUT sees ack equality mem_lat+1 edges after its request edge.
  bit pend = 1'b0;
  int cnt  = 0;
  always @(posedge clk_sys) begin
    if (reset) begin
      mem_ack <= 1'b0;
      mem_q   <= 16'd0;
      pend    <= 1'b0;
    end else if (pend) begin
      if (cnt <= 1) begin
        mem_ack <= mem_req;
        mem_q   <= get_word(mem_a);
        pend    <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (mem_req !== mem_ack) begin
      if (mem_lat <= 1) begin
        mem_ack <= mem_req;
        mem_q   <= get_word(mem_a);
      end else begin
        pend <= 1'b1;
        cnt  <= mem_lat - 1;
      end
    end
  end

  always @(mem_req) if (reset === 1'b0) req_edges++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rd(input logic [24:0] a, input bit raise);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    if (raise) ioctl_upload = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
  endtask

  task automatic read_check(input logic [24:0] a, input string tag, input bit raise);
    int e0, n;
    bit oor, hit;
    if (raise) c_vld = 1'b0;
    oor = (a >= 25'(C_SIZE));
    hit = C_PF && !oor && c_vld && (c_word == word_of(a));
    if (oor) exp_din = 8'hFF;
    else     exp_din = ref_byte(a);
    e0 = req_edges;
    pulse_rd(a, raise);
    n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    chk({tag, " wait cycles"}, n, (oor || hit) ? 0 : mem_lat + 1);
    chk({tag, " din"}, {24'd0, ioctl_din}, {24'd0, exp_din});
    chk({tag, " req edges"}, req_edges - e0, (oor || hit) ? 0 : 1);
    chk({tag, " busy"}, {31'd0, busy}, 0);
    if (!oor) begin
      c_vld  = 1'b1;
      c_word = word_of(a);
    end
  endtask

  initial begin
    int e0, n;
    logic [24:0] a;

    sdram[23'h050800] = 16'hBEEF;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst din", {24'd0, ioctl_din}, 32'hFF);
    chk("rst wait", {31'd0, ioctl_wait}, 0);
    chk("rst req", {31'd0, mem_req}, 0);
    chk("rst mem_a", {9'd0, mem_a}, 0);
    chk("rst busy", {31'd0, busy}, 0);

    // First fetch: 5 wait cycles, checked step by step.
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    @(negedge clk_sys);
    mem_lat = 4;
    e0 = req_edges;
    exp_din = 8'hEF;
    pulse_rd(25'd0, 1'b0);
    chk("a0 wait rise", {31'd0, ioctl_wait}, 1);
    chk("a0 busy", {31'd0, busy}, 1);
    chk("a0 mem_a", {9'd0, mem_a}, 32'h050800);
    chk("a0 req edge", req_edges - e0, 1);
    n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    chk("a0 wait cycles", n, 5);
    chk("a0 din", {24'd0, ioctl_din}, 32'hEF);
    chk("a0 total edges", req_edges - e0, 1);
    c_vld = 1'b1;
    c_word = 23'h050800;

    mem_lat = 3;
    read_check(25'd1, "a1", 1'b0);
    chk("a1 byte", {24'd0, ioctl_din}, 32'hBE);

    read_check(25'd1024, "oor1024", 1'b0);
    read_check(25'd1023, "last1023", 1'b0);
    read_check(25'h1FFFFFF, "oormax", 1'b0);
    mem_lat = 1;
    read_check(25'd6, "minlat", 1'b0);

    // Wrong index: no response at all.
    ioctl_index = 8'd0;
    e0 = req_edges;
    pulse_rd(25'd3, 1'b0);
    repeat (3) @(negedge clk_sys);
    chk("idx din", {24'd0, ioctl_din}, {24'd0, exp_din});
    chk("idx busy", {31'd0, busy}, 0);
    chk("idx wait", {31'd0, ioctl_wait}, 0);
    chk("idx edges", req_edges - e0, 0);
    ioctl_index = 8'd4;

    // Randomized reads, biased toward neighbouring bytes and the range edge.
    for (int i = 0; i < 30; i++) begin
      mem_lat = int'($urandom_range(1, 6));
      case ($urandom_range(0, 5))
        0:       a = 25'(C_SIZE) + 25'($urandom_range(0, 2000));
        1, 2:    a = ioctl_addr ^ 25'd1;
        default: a = 25'($urandom_range(0, C_SIZE - 1));
      endcase
      read_check(a, "rand", 1'b0);
    end

    // Abort mid-fetch, then a fresh upload must refetch.
    mem_lat = 4;
    read_check(25'd0, "pre-abort", 1'b0);
    mem_lat = 10;
    e0 = req_edges;
    pulse_rd(25'd2, 1'b0);
    chk("abort wait rise", {31'd0, ioctl_wait}, 1);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort wait drop", {31'd0, ioctl_wait}, 0);
    chk("abort busy", {31'd0, busy}, 1);
    chk("abort din", {24'd0, ioctl_din}, {24'd0, exp_din});
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk_sys);
    end
    chk("drain busy", {31'd0, busy}, 0);
    chk("drain ack", {31'd0, mem_ack}, {31'd0, mem_req});
    chk("drain edges", req_edges - e0, 1);
    chk("drain din", {24'd0, ioctl_din}, {24'd0, exp_din});
    c_vld = 1'b0;
    mem_lat = 2;
    read_check(25'd1, "reup", 1'b1);
    read_check(25'd0, "reup hit", 1'b0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    read_check(25'd0, "rise rd", 1'b1);

    // Second strobe during FETCH is ignored.
    mem_lat = 6;
    e0 = req_edges;
    exp_din = ref_byte(25'd10);
    pulse_rd(25'd10, 1'b0);
    @(negedge clk_sys);
    pulse_rd(25'd20, 1'b0);
    n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_sys);
    end
    repeat (2) @(negedge clk_sys);
    chk("dup edges", req_edges - e0, 1);
    chk("dup din", {24'd0, ioctl_din}, {24'd0, exp_din});
    chk("dup busy", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
